// File: rtl/mtl_sopc_cpu_mult_arbiter_pkg.sv
// Shared types and constants for the two-port multiplier arbiter and its
// shared 32x16 multiply cell.
package mtl_sopc_cpu_mult_arbiter_pkg;
  localparam int DATA_W       = 32;
  localparam int HALF_W       = 16;
  localparam int CELL_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE1 = 2'd1,
    ST_ISSUE2 = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_id_t;
endpackage

// File: rtl/mtl_sopc_cpu_mult_arbiter_cell.sv
// Registered 32x16 multiply cell: p = (x * y) mod 2^32, one cycle after x/y.
module mtl_sopc_cpu_mult_cell
  import mtl_sopc_cpu_mult_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] x,
  input  logic [HALF_W-1:0] y,
  output logic [DATA_W-1:0] p
);

  logic [DATA_W-1:0] y_ext;

  assign y_ext = {{(DATA_W-HALF_W){1'b0}}, y};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) p <= '0;
    else     p <= x * y_ext;
  end

endmodule

// File: rtl/mtl_sopc_cpu_mult_arbiter.sv
// Two-port arbiter sharing one 32x16 multiply cell; each product is built in
// two passes (low half of src2, then high half shifted) and summed mod 2^32.
module mtl_sopc_cpu_mult_arbiter
  import mtl_sopc_cpu_mult_arbiter_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [DATA_W-1:0] p0_src1,
  input  logic [DATA_W-1:0] p0_src2,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_rsp_result,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [DATA_W-1:0] p1_src1,
  input  logic [DATA_W-1:0] p1_src2,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_rsp_result,
  output logic              busy
);

  state_t            state;
  port_id_t          owner;
  port_id_t          last_grant;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] partial_q;
  logic [DATA_W-1:0] res0_q;
  logic [DATA_W-1:0] res1_q;
  logic              rsp_v0;
  logic              rsp_v1;
  logic              elig0;
  logic              elig1;
  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] cell_x;
  logic [HALF_W-1:0] cell_y;
  logic [DATA_W-1:0] cell_p;

  // A port holding an unconsumed result may not issue again.
  assign elig0 = p0_req_valid & ~rsp_v0;
  assign elig1 = p1_req_valid & ~rsp_v1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n && state == ST_IDLE) begin
      if (elig0 && elig1) begin
        if (RR_ENABLE && last_grant == PORT_0) grant1 = 1'b1;
        else                                   grant0 = 1'b1;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  // Cell operands come only from the latched operand registers.
  always_comb begin
    if (state == ST_ISSUE1) begin
      cell_x = src1_q;
      cell_y = src2_q[HALF_W-1:0];
    end else begin
      cell_x = {src1_q[HALF_W-1:0], {HALF_W{1'b0}}};
      cell_y = src2_q[DATA_W-1:HALF_W];
    end
  end

  mtl_sopc_cpu_mult_cell u_cell (
    .clk (clk),
    .clr (~reset_n),
    .x   (cell_x),
    .y   (cell_y),
    .p   (cell_p)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner      <= PORT_0;
      last_grant <= PORT_1;
      src1_q     <= '0;
      src2_q     <= '0;
      partial_q  <= '0;
      res0_q     <= '0;
      res1_q     <= '0;
      rsp_v0     <= 1'b0;
      rsp_v1     <= 1'b0;
    end else begin
      if (p0_rsp_ready) rsp_v0 <= 1'b0;
      if (p1_rsp_ready) rsp_v1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            src1_q     <= grant1 ? p1_src1 : p0_src1;
            src2_q     <= grant1 ? p1_src2 : p0_src2;
            owner      <= grant1 ? PORT_1 : PORT_0;
            last_grant <= grant1 ? PORT_1 : PORT_0;
            state      <= ST_ISSUE1;
          end
        end
        ST_ISSUE1: state <= ST_ISSUE2;
        ST_ISSUE2: begin
          partial_q <= cell_p;
          state     <= ST_FINISH;
        end
        ST_FINISH: begin
          if (owner == PORT_0) begin
            res0_q <= partial_q + cell_p;
            rsp_v0 <= 1'b1;
          end else begin
            res1_q <= partial_q + cell_p;
            rsp_v1 <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign p0_req_ready  = grant0;
  assign p1_req_ready  = grant1;
  assign p0_rsp_valid  = rsp_v0;
  assign p1_rsp_valid  = rsp_v1;
  assign p0_rsp_result = res0_q;
  assign p1_rsp_result = res1_q;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_mtl_sopc_cpu_mult_arbiter.sv
// Scoreboard bench for the two-port multiplier arbiter (round-robin instance
// plus a fixed-priority instance for the priority check).
module tb_mtl_sopc_cpu_mult_arbiter;

  typedef struct {
    logic [31:0] res;
    int          acc;
  } exp_t;

  typedef struct {
    int port;
    int cyc;
  } gnt_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic        p0_req_ready, p1_req_ready;
  logic [31:0] p0_src1 = '0, p0_src2 = '0, p1_src1 = '0, p1_src2 = '0;
  logic        p0_rsp_valid, p1_rsp_valid;
  logic        p0_rsp_ready = 1'b1, p1_rsp_ready = 1'b1;
  logic [31:0] p0_rsp_result, p1_rsp_result;
  logic        busy;

  logic        f0_req_valid = 1'b0, f1_req_valid = 1'b0;
  logic        f0_req_ready, f1_req_ready;
  logic        f0_rsp_valid, f1_rsp_valid;
  logic [31:0] f0_rsp_result, f1_rsp_result;
  logic        f_busy;

  logic [31:0] e0 = '0, e1 = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          prev0 = 1'b0, prev1 = 1'b0;
  exp_t        q0[$];
  exp_t        q1[$];
  gnt_t        glog[$];
  gnt_t        flog[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mtl_sopc_cpu_mult_arbiter #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_src1(p0_src1), .p0_src2(p0_src2),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_result(p0_rsp_result),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_src1(p1_src1), .p1_src2(p1_src2),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_result(p1_rsp_result),
    .busy(busy)
  );

  mtl_sopc_cpu_mult_arbiter #(.RR_ENABLE(1'b0)) dut_fix (
    .clk(clk), .reset_n(reset_n),
    .p0_req_valid(f0_req_valid), .p0_req_ready(f0_req_ready),
    .p0_src1(32'd3), .p0_src2(32'd5),
    .p0_rsp_valid(f0_rsp_valid), .p0_rsp_ready(1'b1), .p0_rsp_result(f0_rsp_result),
    .p1_req_valid(f1_req_valid), .p1_req_ready(f1_req_ready),
    .p1_src1(32'd7), .p1_src2(32'd9),
    .p1_rsp_valid(f1_rsp_valid), .p1_rsp_ready(1'b1), .p1_rsp_result(f1_rsp_result),
    .busy(f_busy)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_b(string name, logic act, logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endfunction

  // Monitor: log accepts, push expectations, compare presented responses.
  always @(negedge clk) begin
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      prev0 = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (p0_req_valid && p0_req_ready) begin
        q0.push_back('{e0, cyc});
        glog.push_back('{0, cyc});
      end
      if (p1_req_valid && p1_req_ready) begin
        q1.push_back('{e1, cyc});
        glog.push_back('{1, cyc});
      end
      if (p0_rsp_valid) begin
        if (q0.size() == 0) check_b("p0_spurious_rsp", p0_rsp_valid, 1'b0);
        else begin
          check("p0_result", p0_rsp_result, q0[0].res);
          if (!prev0) check("p0_latency", 32'(cyc - q0[0].acc), 32'd4);
          if (p0_rsp_ready) void'(q0.pop_front());
        end
      end
      if (p1_rsp_valid) begin
        if (q1.size() == 0) check_b("p1_spurious_rsp", p1_rsp_valid, 1'b0);
        else begin
          check("p1_result", p1_rsp_result, q1[0].res);
          if (!prev1) check("p1_latency", 32'(cyc - q1[0].acc), 32'd4);
          if (p1_rsp_ready) void'(q1.pop_front());
        end
      end
      prev0 = p0_rsp_valid && !p0_rsp_ready;
      prev1 = p1_rsp_valid && !p1_rsp_ready;

      if (f0_req_valid && f0_req_ready) flog.push_back('{0, cyc});
      if (f1_req_valid && f1_req_ready) flog.push_back('{1, cyc});
      if (f0_req_valid && !f0_rsp_valid && !f_busy) check_b("fix_p1_blocked", f1_req_ready, 1'b0);
      if (f0_rsp_valid) check("fix_p0_result", f0_rsp_result, 32'h0000000F);
      if (f1_rsp_valid) check("fix_p1_result", f1_rsp_result, 32'h0000003F);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    bit done = 1'b0;
    if (port == 0) begin p0_src1 = a; p0_src2 = b; e0 = e; p0_req_valid = 1'b1; end
    else           begin p1_src1 = a; p1_src2 = b; e1 = e; p1_req_valid = 1'b1; end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_req_ready : p1_req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (port == 0) p0_req_valid = 1'b0;
    else           p1_req_valid = 1'b0;
    check_b((port == 0) ? "p0_accept" : "p1_accept", done, 1'b1);
  endtask

  task automatic wait_log(input bit fixed, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      #1;
      if ((fixed ? flog.size() : glog.size()) >= n) ok = 1'b1;
    end
    check_b("grant_wait", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick(1);
      if (q0.size() == 0 && q1.size() == 0 && !busy) ok = 1'b1;
    end
    check_b("drain", ok, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_busy"}, busy, 1'b0);
    check_b({tag, "_p0_req_ready"}, p0_req_ready, 1'b0);
    check_b({tag, "_p1_req_ready"}, p1_req_ready, 1'b0);
    check_b({tag, "_p0_rsp_valid"}, p0_rsp_valid, 1'b0);
    check_b({tag, "_p1_rsp_valid"}, p1_rsp_valid, 1'b0);
    check({tag, "_p0_result"}, p0_rsp_result, 32'h0);
    check({tag, "_p1_result"}, p1_rsp_result, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n0;
    // Reset state, with requests asserted to confirm ready is held low.
    #1 reset_n = 1'b0;
    p0_req_valid = 1'b1;
    p1_req_valid = 1'b1;
    tick(2);
    check_reset_outputs("rst");
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    reset_n = 1'b1;
    tick(1);

    // Basic products, including the two-pass-sensitive vector.
    issue(0, 32'h00010003, 32'h00020005, 32'h000B000F);
    wait_idle();
    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    issue(1, 32'h80000000, 32'h00000002, 32'h00000000);
    wait_idle();

    // Round-robin from reset with both ports continuously requesting.
    reset_n = 1'b0;
    glog.delete();
    p0_src1 = 32'd3; p0_src2 = 32'd5; e0 = 32'd15;
    p1_src1 = 32'd7; p1_src2 = 32'd9; e1 = 32'd63;
    p0_req_valid = 1'b1;
    p1_req_valid = 1'b1;
    tick(2);
    reset_n = 1'b1;
    wait_log(1'b0, 4);
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      check("rr_order", 32'(glog[i].port), 32'(i % 2));
      if (i > 0) check("rr_spacing", 32'(glog[i].cyc - glog[i-1].cyc), 32'd4);
    end
    wait_idle();

    // Stalled p0 response must not block p1 nor allow p0 re-accept.
    glog.delete();
    p0_rsp_ready = 1'b0;
    p0_src1 = 32'd2; p0_src2 = 32'd3; e0 = 32'd6;
    p1_src1 = 32'd4; p1_src2 = 32'd5; e1 = 32'd20;
    p0_req_valid = 1'b1;
    wait_log(1'b0, 1);
    @(posedge clk); #1;
    p1_req_valid = 1'b1;
    wait_log(1'b0, 3);
    @(posedge clk); #1;
    p1_req_valid = 1'b0;
    tick(6);
    check("stall_log_size", 32'(glog.size()), 32'd3);
    for (int i = 0; i < 3 && i < glog.size(); i++)
      check("stall_grant_port", 32'(glog[i].port), (i == 0) ? 32'd0 : 32'd1);
    check_b("stall_p0_held", p0_rsp_valid, 1'b1);
    c0 = cyc;
    p0_rsp_ready = 1'b1;
    tick(1);
    p0_rsp_ready = 1'b0;
    wait_log(1'b0, 4);
    if (glog.size() >= 4) begin
      check("reaccept_port", 32'(glog[3].port), 32'd0);
      check("reaccept_cycle", 32'(glog[3].cyc), 32'(c0 + 1));
    end
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    p0_rsp_ready = 1'b1;
    wait_idle();

    // Reset during ISSUE2 discards the operation.
    issue(0, 32'h00010003, 32'h00020005, 32'h000B000F);
    @(posedge clk); #1;
    check_b("issue2_busy", busy, 1'b1);
    p1_req_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    p1_req_valid = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(8);
    check_b("post_rst_p0_rsp", p0_rsp_valid, 1'b0);
    check_b("post_rst_busy", busy, 1'b0);
    fork
      issue(0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001);
      issue(1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
    join
    wait_idle();

    // Fixed priority: p0 wins whenever both are eligible.
    flog.delete();
    f0_req_valid = 1'b1;
    wait_log(1'b1, 1);
    n0 = (flog.size() > 0) ? flog[0].cyc : cyc;
    tick(1);
    for (int i = 0; i < 20 && cyc < n0 + 5; i++) tick(1);
    f1_req_valid = 1'b1;
    wait_log(1'b1, 4);
    @(posedge clk); #1;
    f0_req_valid = 1'b0;
    f1_req_valid = 1'b0;
    for (int i = 0; i < 4 && i < flog.size(); i++) begin
      check("fix_order", 32'(flog[i].port), (i == 2) ? 32'd1 : 32'd0);
      check("fix_cycle", 32'(flog[i].cyc - n0),
            (i == 0) ? 32'd0 : (i == 1) ? 32'd5 : (i == 2) ? 32'd9 : 32'd13);
    end
    tick(12);

    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mtl_sopc_cpu_mult_arbiter.md
MTL_SOPC_CPU_MULT_ARBITER -- requirements
Module: mtl_sopc_cpu_mult_arbiter

Interface
REQ-001 Parameter: RR_ENABLE, 1, 1 = round-robin arbitration between ports, 0 = fixed priority with port 0 highest.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 p0_req_valid / p1_req_valid  input  1  requester has an operation pending.
REQ-005 p0_req_ready / p1_req_ready  output  1  operation accepted this cycle.
REQ-006 p0_src1, p0_src2 / p1_src1, p1_src2  input  32  operands; sampled only on accept.
REQ-007 p0_rsp_valid / p1_rsp_valid  output  1  result available.
REQ-008 p0_rsp_ready / p1_rsp_ready  input  1  requester consumes result.
REQ-009 p0_rsp_result / p1_rsp_result  output  32  low 32 bits of src1*src2.
REQ-010 busy  output  1  FSM not in IDLE.

Function
REQ-011 Result SHALL be (src1*src2) mod 2^32; identical for signed and unsigned operands.
REQ-012 The cell SHALL compute cell(x,y) = (x * y[15:0]) mod 2^32, with result valid one cycle after inputs are applied.
REQ-013 The full product SHALL be built in two passes: pass1 = cell(src1, src2); pass2 = cell({src1[15:0],16'h0}, {16'h0,src2[31:16]}); result = (pass1 + pass2) mod 2^32.
REQ-014 FSM states SHALL be IDLE -> ISSUE1 -> ISSUE2 -> FINISH -> IDLE, with no other transitions.
REQ-015 Port i SHALL be eligible in IDLE when pi_req_valid=1 and pi_rsp_valid=0.
REQ-016 Exactly one eligible port SHALL get pi_req_ready=1 in IDLE; operands and owner id SHALL latch at that edge, and the FSM SHALL enter ISSUE1.
REQ-017 req_ready SHALL be a combinational function of the FSM state, the eligibility of both ports and the priority pointer, and SHALL be 0 outside IDLE.
REQ-018 When RR_ENABLE=1 and both ports are eligible, the port not granted last SHALL win.
REQ-019 When RR_ENABLE=0 and both ports are eligible, port 0 SHALL always win.
REQ-020 ISSUE1 SHALL drive the pass1 operands to the cell.
REQ-021 ISSUE2 SHALL drive the pass2 operands and latch the cell output as the partial product.
REQ-022 FINISH SHALL write partial + cell output to the owner's result register and set the owner's rsp_valid at that edge.
REQ-023 Latency: accept edge at end of cycle N; rsp_valid high in cycle N+4.
REQ-024 Throughput: at most one accept every 4 cycles.
REQ-025 rsp_valid and rsp_result SHALL hold stable until a cycle with rsp_ready=1, which clears rsp_valid at that edge.
REQ-026 A response pop in IDLE SHALL NOT make that port eligible in the same cycle.
REQ-027 A stalled response on one port SHALL NOT block service of the other port.

Reset
REQ-028 Reset SHALL be asynchronous and active-low, and SHALL take effect mid-operation: FSM to IDLE; all req_ready, rsp_valid and busy to 0; result registers, operand registers and partial register to 0; RR pointer to "port 1 granted last".
REQ-029 An operation in flight when reset asserts SHALL be discarded and produce no response.
REQ-030 The cell's clear input SHALL be driven from ~reset_n.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration, the port-id type and the constant CELL_LATENCY=1.
REQ-032 One sub-module SHALL exist: an instance of MTL_SOPC_CPU_mult_cell, driven from registered operand muxes only (no combinational path from req inputs).

Verification
REQ-033 p0 issues 0x00010003 * 0x00020005 -> p0_rsp_result=0x000B000F in cycle N+4 (a pass1-only bug gives 0x0005000F).
REQ-034 p1 issues 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001; p1 issues 0x80000000 * 0x00000002 -> 0x00000000.
REQ-035 RR_ENABLE=1, both ports request continuously from reset -> grant order p0, p1, p0, p1, with accepts spaced 4 cycles apart.
REQ-036 p0_rsp_ready held 0 with p0_req_valid=1 -> p0 result held stable and p0 not re-accepted while p1 is served; p0 is re-accepted on the first IDLE cycle after the pop.
REQ-037 reset_n pulsed low during ISSUE2 -> all outputs 0 immediately; after release, no rsp_valid appears and a fresh request completes correctly.
REQ-038 RR_ENABLE=0, both ports request continuously -> p1 is never granted while p0 stays eligible.
